// File: rtl/evb_arbiter.sv
// Round-robin arbiter that shares one EVB command channel between NUM_MASTERS four-phase requesters.
// Optional downstream timeout is compiled in when EVB_TIMEOUT_EN is defined.
module evb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    output logic [NUM_MASTERS-1:0]        m_finish,
    output logic [DATA_W-1:0]             m_rd_data,
    output logic                          evb_cmd_request,
    output logic [ADDR_W-1:0]             evb_cmd_addr,
    input  logic                          evb_cmd_finish,
    input  logic [DATA_W-1:0]             evb_cmd_rd_data,
    output logic [((NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1)-1:0] grant_id,
    output logic                          timeout_err
);
    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                   state_reg, state_next;
    logic [GW-1:0]            rr_reg, rr_next;
    logic [GW-1:0]            gid_reg, gid_next;
    logic                     req_reg, req_next;
    logic [ADDR_W-1:0]        addr_reg, addr_next;
    logic [NUM_MASTERS-1:0]   fin_reg, fin_next;
    logic [DATA_W-1:0]        rd_reg, rd_next;
    logic [GW-1:0]            sel_idx;
    logic [GW-1:0]            gid_inc;
    logic                     any_req;
    logic                     own_req;
    logic [GW-1:0]            cand [NUM_MASTERS];

    // cand[i] is the master index i places after the round-robin pointer, wrapped.
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
            logic [GW:0] sum;
            assign sum = {1'b0, rr_reg} + (GW+1)'(gi);
            assign cand[gi] = (sum >= (GW+1)'(NUM_MASTERS)) ?
                              GW'(sum - (GW+1)'(NUM_MASTERS)) : sum[GW-1:0];
        end
    endgenerate

    // Scan from farthest to nearest so the closest requester to the pointer wins.
    always_comb begin
        sel_idx = rr_reg;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (m_req[cand[i]]) begin
                sel_idx = cand[i];
            end
        end
    end

    assign any_req = |m_req;
    assign own_req = m_req[gid_reg];
    assign gid_inc = (gid_reg == GW'(NUM_MASTERS - 1)) ? '0 : gid_reg + 1'b1;

`ifdef EVB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          terr_reg, terr_next;
    logic          timeout_hit;
    assign timeout_hit = (cnt_reg == CW'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = GRANT;
            GRANT: begin
                if (evb_cmd_finish)  state_next = DONE;
                else if (!own_req)   state_next = RELEASE;
`ifdef EVB_TIMEOUT_EN
                else if (timeout_hit) state_next = DONE;
`endif
            end
            DONE:    if (!own_req) state_next = RELEASE;
            RELEASE: if (!evb_cmd_finish) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_next  = req_reg;
        addr_next = addr_reg;
        gid_next  = gid_reg;
        fin_next  = fin_reg;
        rd_next   = rd_reg;
        rr_next   = rr_reg;
`ifdef EVB_TIMEOUT_EN
        cnt_next  = cnt_reg;
        terr_next = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    gid_next  = sel_idx;
                    addr_next = m_addr[sel_idx*ADDR_W +: ADDR_W];
                    req_next  = 1'b1;
`ifdef EVB_TIMEOUT_EN
                    cnt_next  = '0;
`endif
                end
            end
            GRANT: begin
                if (evb_cmd_finish) begin
                    rd_next           = evb_cmd_rd_data;
                    fin_next          = '0;
                    fin_next[gid_reg] = 1'b1;
                end else if (!own_req) begin
                    // Aborted transactions still move the pointer so nobody is locked out.
                    req_next = 1'b0;
                    rr_next  = gid_inc;
                end
`ifdef EVB_TIMEOUT_EN
                else if (timeout_hit) begin
                    req_next          = 1'b0;
                    rd_next           = DATA_W'(32'hDEAD_BEEF);
                    fin_next          = '0;
                    fin_next[gid_reg] = 1'b1;
                    terr_next         = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
`endif
            end
            DONE: begin
                if (!own_req) begin
                    fin_next = '0;
                    req_next = 1'b0;
                    rr_next  = gid_inc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_reg   <= '0;
            gid_reg  <= '0;
            req_reg  <= 1'b0;
            addr_reg <= '0;
            fin_reg  <= '0;
            rd_reg   <= '0;
        end else begin
            rr_reg   <= rr_next;
            gid_reg  <= gid_next;
            req_reg  <= req_next;
            addr_reg <= addr_next;
            fin_reg  <= fin_next;
            rd_reg   <= rd_next;
        end
    end

`ifdef EVB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            terr_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            terr_reg <= terr_next;
        end
    end
    assign timeout_err = terr_reg;
`else
    assign timeout_err = 1'b0;
`endif

    assign m_finish        = fin_reg;
    assign m_rd_data       = rd_reg;
    assign evb_cmd_request = req_reg;
    assign evb_cmd_addr    = addr_reg;
    assign grant_id        = gid_reg;

endmodule

// File: tb/tb_evb_arbiter.sv
// Scoreboard bench for evb_arbiter: directed scenarios plus randomized request/abort/latency mixes
// checked against a round-robin reference model.
module tb_evb_arbiter;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      m_req;
    logic [N*AW-1:0]   m_addr;
    logic [N-1:0]      m_finish;
    logic [DW-1:0]     m_rd_data;
    logic              evb_cmd_request;
    logic [AW-1:0]     evb_cmd_addr;
    logic              evb_cmd_finish;
    logic [DW-1:0]     evb_cmd_rd_data;
    logic [1:0]        grant_id;
    logic              timeout_err;

    logic [AW-1:0]     addr_v [N];

    typedef struct {
        int         id;
        logic [63:0] val;
    } exp_t;

    exp_t  grant_q[$];
    exp_t  fin_q[$];
    int    obs_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    int    rr_m   = 0;
    bit [N-1:0] pend = '0;
    bit    prev_normal = 1'b1;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pack
            assign m_addr[gi*AW +: AW] = addr_v[gi];
        end
    endgenerate

    evb_arbiter #(
        .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_addr(m_addr),
        .m_finish(m_finish), .m_rd_data(m_rd_data),
        .evb_cmd_request(evb_cmd_request), .evb_cmd_addr(evb_cmd_addr),
        .evb_cmd_finish(evb_cmd_finish), .evb_cmd_rd_data(evb_cmd_rd_data),
        .grant_id(grant_id), .timeout_err(timeout_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: expected DUT event did not occur within its cycle budget", name);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "bench aborted");
    endtask

    // Reference: first pending master at or after the pointer, wrapping.
    function automatic int model_grant();
        for (int i = 0; i < N; i++) begin
            if (pend[(rr_m + i) % N]) return (rr_m + i) % N;
        end
        return -1;
    endfunction

    // Monitor: pops expectations whenever a new grant or a finish appears.
    initial begin
        logic         prev_req = 1'b0;
        logic [N-1:0] prev_fin = '0;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (evb_cmd_request && !prev_req) begin
                obs_q.push_back(int'(grant_id));
                if (grant_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_grant: grant_id=%0d, no grant required", grant_id);
                end else begin
                    e = grant_q.pop_front();
                    check("grant_id", 64'(grant_id), 64'(e.id));
                    check("grant_addr", 64'(evb_cmd_addr), e.val);
                    $display("grant  master=%0d addr=0x%04h", grant_id, evb_cmd_addr);
                end
            end
            if (m_finish != 0 && prev_fin == 0) begin
                check("finish_onehot", 64'($onehot(m_finish)), 64'd1);
                if (fin_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_finish: m_finish=0x%0h, no finish required", m_finish);
                end else begin
                    e = fin_q.pop_front();
                    check("finish_master", 64'(m_finish), 64'(4'b0001 << e.id));
                    check("rd_data", 64'(m_rd_data), e.val);
                    $display("finish master=%0d data=0x%08h", e.id, m_rd_data);
                end
            end
`ifndef EVB_TIMEOUT_EN
            check("timeout_err_low", 64'(timeout_err), 64'd0);
`endif
            prev_req = evb_cmd_request;
            prev_fin = m_finish;
        end
    end

    // One full transaction: raise requests, expect the model's grant, then complete, abort or time out.
    task automatic do_txn(input bit [N-1:0] add, input logic [AW-1:0] fix_addr, input bit use_fix,
                          input logic [DW-1:0] data, input bit abort, input int lat,
                          input int hold, input bit longw);
        int g;
        int cyc;
        int bad;
        exp_t e;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (add[k] && !pend[k]) begin
                addr_v[k] = use_fix ? fix_addr : AW'($urandom);
                pend[k]   = 1'b1;
                m_req[k]  = 1'b1;
            end
        end
        g = model_grant();
        e.id = g; e.val = 64'(addr_v[g]);
        grant_q.push_back(e);
        if (prev_normal) begin
            @(negedge clk);
            check("req_latency", 64'(evb_cmd_request), 64'd1);
        end else begin
            cyc = 0;
            while (!evb_cmd_request && cyc < 8) begin @(negedge clk); cyc++; end
            if (!evb_cmd_request) bound_fail("grant_wait");
        end
        if (abort) begin
            repeat (lat) @(negedge clk);
            m_req[g] = 1'b0; pend[g] = 1'b0; rr_m = (g + 1) % N;
            @(negedge clk);
            check("abort_req_low", 64'(evb_cmd_request), 64'd0);
            check("abort_no_finish", 64'(m_finish), 64'd0);
            $display("abort  master=%0d", g);
            prev_normal = 1'b0;
            return;
        end
        if (longw) begin
`ifdef EVB_TIMEOUT_EN
            e.id = g; e.val = 64'(32'hDEAD_BEEF);
            fin_q.push_back(e);
            cyc = 0;
            while (m_finish == 0 && cyc < 40) begin @(negedge clk); cyc++; end
            check("timeout_cycles", 64'(cyc), 64'(TO));
            check("timeout_err_pulse", 64'(timeout_err), 64'd1);
            check("timeout_req_low", 64'(evb_cmd_request), 64'd0);
            @(negedge clk);
            check("timeout_err_end", 64'(timeout_err), 64'd0);
`else
            bad = 0;
            repeat (1000) begin
                @(negedge clk);
                if (!evb_cmd_request || m_finish != 0) bad++;
            end
            check("long_wait_held", 64'(bad), 64'd0);
`endif
        end
        if (!longw || m_finish == 0) begin
            repeat (lat) @(negedge clk);
            evb_cmd_finish  = 1'b1;
            evb_cmd_rd_data = data;
            e.id = g; e.val = 64'(data);
            fin_q.push_back(e);
            cyc = 0;
            while (!m_finish[g] && cyc < 4) begin @(negedge clk); cyc++; end
            if (!m_finish[g]) bound_fail("finish_wait");
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        check("finish_held", 64'(m_finish), 64'(4'b0001 << g));
        m_req[g] = 1'b0; pend[g] = 1'b0; rr_m = (g + 1) % N;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("release_req_low", 64'(evb_cmd_request), 64'd0);
            if (h == 0) check("release_finish_low", 64'(m_finish), 64'd0);
        end
        evb_cmd_finish = 1'b0;
        prev_normal = 1'b1;
    endtask

    initial begin
        int base;
        int order [5];
        bit [N-1:0] add;
        rst_n = 1'b0; m_req = '0; evb_cmd_finish = 1'b0; evb_cmd_rd_data = '0;
        for (int k = 0; k < N; k++) addr_v[k] = '0;
        repeat (3) @(negedge clk);
        check("rst_req", 64'(evb_cmd_request), 64'd0);
        check("rst_finish", 64'(m_finish), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_rd_data", 64'(m_rd_data), 64'd0);
        check("rst_addr", 64'(evb_cmd_addr), 64'd0);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);
        rst_n = 1'b1;

        do_txn(4'b0001, 16'h0010, 1'b1, 32'h1234_5678, 1'b0, 3, 1, 1'b0);

        // Reset in the middle of a grant to master 2.
        @(negedge clk);
        m_req = 4'b0100; pend = 4'b0100; addr_v[2] = 16'hA5A5;
        grant_q.push_back('{id: 2, val: 64'h0000_0000_0000_A5A5});
        @(negedge clk);
        check("pre_reset_req", 64'(evb_cmd_request), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req", 64'(evb_cmd_request), 64'd0);
        check("async_rst_finish", 64'(m_finish), 64'd0);
        check("async_rst_grant_id", 64'(grant_id), 64'd0);
        m_req = '0; pend = '0; rr_m = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        prev_normal = 1'b1;

        base = obs_q.size();
        do_txn(4'b1111, '0, 1'b0, $urandom, 1'b0, 1, 1, 1'b0);
        do_txn(4'b0000, '0, 1'b0, $urandom, 1'b0, 0, 1, 1'b0);
        do_txn(4'b0000, '0, 1'b0, $urandom, 1'b0, 2, 1, 1'b0);
        do_txn(4'b0000, '0, 1'b0, $urandom, 1'b0, 0, 2, 1'b0);
        do_txn(4'b0001, '0, 1'b0, $urandom, 1'b0, 1, 1, 1'b0);
        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) check("rr_order", 64'(obs_q[base + i]), 64'(order[i]));

        do_txn(4'b0100, '0, 1'b0, $urandom, 1'b1, 1, 1, 1'b0);
        do_txn(4'b1001, '0, 1'b0, $urandom, 1'b0, 1, 1, 1'b0);
        check("after_abort_grant", 64'(obs_q[obs_q.size() - 1]), 64'd3);

        do_txn(4'b0010, '0, 1'b0, $urandom, 1'b0, 2, 1, 1'b1);
        do_txn(4'b0101, '0, 1'b0, $urandom, 1'b0, 1, 3, 1'b0);

        for (int it = 0; it < 40; it++) begin
            add = N'($urandom_range(0, 15));
            if ((pend | add) == 0) add = N'(1 << $urandom_range(0, N - 1));
            do_txn(add, '0, 1'b0, $urandom, ($urandom_range(0, 4) == 0),
                   $urandom_range(0, 4), $urandom_range(1, 3), 1'b0);
        end
        while (pend != 0) do_txn('0, '0, 1'b0, $urandom, 1'b0, 0, 1, 1'b0);

        repeat (4) @(negedge clk);
        check("grant_q_drained", 64'(grant_q.size()), 64'd0);
        check("fin_q_drained", 64'(fin_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        bound_fail("global_watchdog");
    end

endmodule
